// File: rtl/board_pkg.sv
// Shared constants and types for the board button front end.
package board_pkg;
    localparam int NUM_BTN  = 6;
    localparam int BTN_STEP = 0;
    localparam int BTN_RST  = 1;
    localparam int BTN_PAGE = 5;
    localparam logic [2:0] PAGE_BLANK = 3'd7;

    typedef enum logic {ST_IDLE, ST_PULSE} step_state_e;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level and rise pulse.
module btn_debounce
    import board_pkg::*;
#(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            if (sync_q[1] != level) begin
                // DEB_CYCLES consecutive mismatching samples are needed to flip the level
                if (cnt == CNT_MAX) begin
                    cnt   <= '0;
                    level <= ~level;
                    rise  <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/board_input.sv
// Board button front end: debounced buttons, CPU single-step pulse, reset request, page select.
module board_input
    import board_pkg::*;
#(
    parameter int DEB_CYCLES = 100000,
    parameter int STEP_LEN   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic               step_clk,
    output logic               step_busy,
    output logic               cpu_rst,
    output logic [2:0]         page,
    output logic               page_valid
);
    localparam int SW = $clog2(STEP_LEN) + 1;
    localparam logic [SW-1:0] LEN_LOAD = SW'(STEP_LEN - 1);

    step_state_e   state;
    logic [SW-1:0] len;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i])
        );
    end

    // Presses landing mid-pulse are dropped, never queued or used to stretch the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len      <= '0;
            step_clk <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_rise[BTN_STEP]) begin
                        state    <= ST_PULSE;
                        len      <= LEN_LOAD;
                        step_clk <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (len == '0) begin
                        state    <= ST_IDLE;
                        step_clk <= 1'b0;
                    end else begin
                        len <= len - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    step_clk <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            page <= '0;
        else if (btn_rise[BTN_PAGE])
            page <= page + 3'd1;
    end

    assign step_busy  = step_clk;
    assign cpu_rst    = btn_level[BTN_RST];
    assign page_valid = (page != PAGE_BLANK);
endmodule

// File: tb/tb_board_input.sv
// Directed bench for board_input with short debounce; a second instance exercises a mid-pulse press.
module tb_board_input;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn_raw = '0;
    logic [5:0] btn_level, btn_rise;
    logic       step_clk, step_busy, cpu_rst, page_valid;
    logic [2:0] page;

    logic [5:0] raw2 = '0;
    logic [5:0] level2, rise2;
    logic       step2, busy2, rst2, valid2;
    logic [2:0] page2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    board_input #(.DEB_CYCLES(8), .STEP_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_rise(btn_rise), .step_clk(step_clk), .step_busy(step_busy),
        .cpu_rst(cpu_rst), .page(page), .page_valid(page_valid)
    );

    board_input #(.DEB_CYCLES(2), .STEP_LEN(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw2), .btn_level(level2),
        .btn_rise(rise2), .step_clk(step2), .step_busy(busy2),
        .cpu_rst(rst2), .page(page2), .page_valid(valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_level", btn_level, 0);
        chk("rst_rise", btn_rise, 0);
        chk("rst_step", step_clk, 0);
        chk("rst_busy", step_busy, 0);
        chk("rst_cpu", cpu_rst, 0);
        chk("rst_page", page, 0);
        chk("rst_valid", page_valid, 1);
        rst_n = 1'b1;
        tick();

        // 5-cycle glitch on button 1 is filtered
        btn_raw[0] = 1'b1;
        repeat (5) tick();
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("glitch_level", btn_level[0], 0);
            chk("glitch_step", step_clk, 0);
        end

        // held press: rise at cycle 10, step pulse for cycles 11..14
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("press_level", btn_level[0], (k >= 10));
            chk("press_rise", btn_rise[0], (k == 10));
            chk("press_step", step_clk, (k >= 11 && k <= 14));
            chk("press_busy", step_busy, (k >= 11 && k <= 14));
        end
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("release_level", btn_level[0], (k < 10));
            chk("release_rise", btn_rise, 0);
        end

        // second accepted press while the pulse is running is discarded
        for (int k = 1; k <= 14; k++) begin
            raw2[0] = (k <= 2 || k >= 5);
            tick();
            chk("mid_rise", rise2[0], (k == 4 || k == 8));
            chk("mid_step", step2, (k >= 5 && k <= 8));
        end
        raw2[0] = 1'b0;

        // page presses 1..8 walk 1..7 then wrap to 0
        for (int i = 1; i <= 8; i++) begin
            btn_raw[5] = 1'b1;
            repeat (11) tick();
            chk("page_val", page, i % 8);
            chk("page_valid", page_valid, (i != 7));
            btn_raw[5] = 1'b0;
            repeat (10) tick();
        end

        // 9th page press together with button 2: both rise in the same cycle
        btn_raw[5] = 1'b1;
        btn_raw[1] = 1'b1;
        repeat (10) tick();
        chk("dual_rise", btn_rise, 6'b100010);
        tick();
        chk("page_9th", page, 1);
        chk("cpu_rst_hi", cpu_rst, 1);
        btn_raw[5] = 1'b0;
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("dual_fall", {btn_level[5], btn_level[1]}, (k < 10) ? 2'b11 : 2'b00);
            chk("dual_norise", btn_rise, 0);
            chk("cpu_rst_f", cpu_rst, (k < 10));
        end

        // bring page to 5, then reset in the middle of a step pulse
        for (int i = 0; i < 4; i++) begin
            btn_raw[5] = 1'b1;
            repeat (11) tick();
            btn_raw[5] = 1'b0;
            repeat (10) tick();
        end
        chk("page_five", page, 5);
        btn_raw[0] = 1'b1;
        repeat (12) tick();
        chk("pre_rst_step", step_clk, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_step", step_clk, 0);
        chk("arst_busy", step_busy, 0);
        chk("arst_page", page, 0);
        chk("arst_valid", page_valid, 1);
        chk("arst_level", btn_level, 0);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("post_rise", btn_rise[0], (k == 10));
            chk("post_step", step_clk, (k >= 11 && k <= 14));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
